// File: rtl/radix8_ntt_ctrl_if.sv
// Control/coefficient-bus bundle between the NTT sequencer and its memory/twiddle side.
interface radix8_ntt_ctrl_if #(
  parameter int LOG2N = 6
) ();
  localparam int S  = LOG2N / 3;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int GW = LOG2N - 3;
  localparam int IW = 8 * LOG2N;

  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [SW-1:0] tw_stage;
  logic [GW-1:0] tw_group;

  // sequencer side
  modport master (
    input  start,
    output busy, done, rd_en, rd_idx, wr_en, wr_idx, tw_stage, tw_group
  );

  // requester / memory side
  modport slave (
    output start,
    input  busy, done, rd_en, rd_idx, wr_en, wr_idx, tw_stage, tw_group
  );
endinterface

// File: rtl/radix8_ntt_ctrl.sv
// Radix-8 in-place NTT sequencer: group reads, delayed in-place writes,
// per-stage read-after-write barrier, done pulse at the end of the last stage.

// One butterfly lane: insert the 3-bit lane number into the group bits at i_sh.
module radix8_ntt_lane #(
  parameter int LOG2N = 6,
  parameter int K     = 0,
  parameter int SHW   = 8
) (
  input  logic [LOG2N-4:0] i_group,
  input  logic [SHW-1:0]   i_sh,
  output logic [LOG2N-1:0] o_idx
);
  logic [LOG2N-1:0] w_g;
  logic [LOG2N-1:0] w_lo_mask;

  assign w_g       = LOG2N'(i_group);
  assign w_lo_mask = (LOG2N'(1) << i_sh) - LOG2N'(1);
  // low bits stay, high bits move up one digit, lane number fills the gap
  assign o_idx = ((w_g & ~w_lo_mask) << 3) | (LOG2N'(K) << i_sh) | (w_g & w_lo_mask);
endmodule

module radix8_ntt_ctrl #(
  parameter int LOG2N  = 6,
  parameter int RD_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  radix8_ntt_ctrl_if.master     io_bus
);
  localparam int S   = LOG2N / 3;
  localparam int G   = 1 << (LOG2N - 3);
  localparam int GW  = LOG2N - 3;
  localparam int SW  = (S > 1) ? $clog2(S) : 1;
  localparam int DW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int IW  = 8 * LOG2N;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_group, w_group_nxt;
  logic [SW-1:0] r_stage, w_stage_nxt;
  logic [DW-1:0] r_dcnt,  w_dcnt_nxt;

  logic                      w_rd_en;
  logic [7:0]                w_sh;
  logic [7:0][LOG2N-1:0]     w_lane_idx;
  logic [IW-1:0]             w_rd_idx;

  logic [RD_LAT-1:0]         r_vld_pipe;
  logic [RD_LAT-1:0][IW-1:0] r_idx_pipe;
  logic [RD_LAT-1:0][SW-1:0] r_stg_pipe;
  logic [RD_LAT-1:0][GW-1:0] r_grp_pipe;

  // state and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_group <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_group <= w_group_nxt;
      r_stage <= w_stage_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // next-state: sweep groups, drain the read latency, advance stage or finish
  always_comb begin
    w_state_nxt = r_state;
    w_group_nxt = r_group;
    w_stage_nxt = r_stage;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      IDLE: if (io_bus.start) begin
        w_state_nxt = RUN;
        w_group_nxt = '0;
        w_stage_nxt = '0;
      end
      RUN: if (r_group == GW'(G - 1)) begin
        w_state_nxt = DRAIN;
        w_dcnt_nxt  = DW'(RD_LAT - 1);
      end else begin
        w_group_nxt = r_group + GW'(1);
      end
      DRAIN: if (r_dcnt == '0) begin
        if (r_stage == SW'(S - 1)) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = RUN;
          w_stage_nxt = r_stage + SW'(1);
          w_group_nxt = '0;
        end
      end else begin
        w_dcnt_nxt = r_dcnt - DW'(1);
      end
      FIN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_en = (r_state == RUN);
  // DIF: stage s works on digit S-1-s, i.e. bit position 3*(S-1-s)
  assign w_sh    = 8'(3 * (S - 1 - int'(r_stage)));

  for (genvar k = 0; k < 8; k++) begin : g_lane
    radix8_ntt_lane #(.LOG2N(LOG2N), .K(k), .SHW(8)) u_lane (
      .i_group (r_group),
      .i_sh    (w_sh),
      .o_idx   (w_lane_idx[k])
    );
  end

  // indices are forced to zero while idle so every output reads 0 outside a read
  assign w_rd_idx = w_rd_en ? IW'(w_lane_idx) : '0;

  // write-side delay line matching the memory read latency
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
      r_stg_pipe <= '0;
      r_grp_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd_en;
      r_idx_pipe[0] <= w_rd_idx;
      r_stg_pipe[0] <= w_rd_en ? r_stage : '0;
      r_grp_pipe[0] <= w_rd_en ? r_group : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_idx_pipe[i] <= r_idx_pipe[i-1];
        r_stg_pipe[i] <= r_stg_pipe[i-1];
        r_grp_pipe[i] <= r_grp_pipe[i-1];
      end
    end
  end

  assign io_bus.busy     = (r_state == RUN) || (r_state == DRAIN);
  assign io_bus.done     = (r_state == FIN);
  assign io_bus.rd_en    = w_rd_en;
  assign io_bus.rd_idx   = w_rd_idx;
  assign io_bus.wr_en    = r_vld_pipe[RD_LAT-1];
  assign io_bus.wr_idx   = r_idx_pipe[RD_LAT-1];
  assign io_bus.tw_stage = r_stg_pipe[RD_LAT-1];
  assign io_bus.tw_group = r_grp_pipe[RD_LAT-1];
endmodule
